// File: rtl/risc32_io_ctrl.sv
// Memory-mapped LED/SEG/SW/BTN controller with per-bit debounce, W1C button events and 7-seg scan.
// Optional button interrupt: define IO_BTN_IRQ_EN.
module risc32_io_db_lane #(
  parameter int DB_CNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic din,
  input  logic dq,
  output logic nxt
);
  localparam int CW = $clog2(DB_CNT + 1);
  localparam logic [CW-1:0] LAST = CW'(DB_CNT - 1);

  logic [CW-1:0] cnt;

  // nxt is the debounced level after this edge; the top owns the level register
  always_comb begin
    nxt = dq;
    if (tick && (din != dq) && (cnt == LAST)) nxt = ~dq;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      if (din != dq) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      else           cnt <= '0;
    end
  end
endmodule

module risc32_io_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int LED_W    = 16,
  parameter int SW_W     = 16,
  parameter int BTN_W    = 5,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int DB_TICK  = 100000,
  parameter int DB_CNT   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  input  logic [SW_W-1:0]   sw,
  input  logic [BTN_W-1:0]  btn,
  output logic [LED_W-1:0]  led,
  output logic [DIGITS-1:0] an_o,
  output logic [7:0]        seg_o,
  output logic              irq_o
);
  localparam int IN_W  = SW_W + BTN_W;
  localparam int SEG_W = 4 * DIGITS;
  localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int TW    = $clog2(DB_TICK + 1);
  localparam int DW    = $clog2(SCAN_DIV + 1);

  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 8'hC0; 4'h1: hex7 = 8'hF9; 4'h2: hex7 = 8'hA4; 4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99; 4'h5: hex7 = 8'h92; 4'h6: hex7 = 8'h82; 4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80; 4'h9: hex7 = 8'h90; 4'hA: hex7 = 8'h88; 4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6; 4'hD: hex7 = 8'hA1; 4'hE: hex7 = 8'h86; default: hex7 = 8'h8E;
    endcase
  endfunction

  logic sel_led, sel_seg, sel_sw, sel_btn, sel_evt, sel_ctrl, wr, rd;
  assign sel_led  = addr_i == BASE_ADDR;
  assign sel_seg  = addr_i == BASE_ADDR + 32'h04;
  assign sel_sw   = addr_i == BASE_ADDR + 32'h08;
  assign sel_btn  = addr_i == BASE_ADDR + 32'h0C;
  assign sel_evt  = addr_i == BASE_ADDR + 32'h10;
  assign sel_ctrl = addr_i == BASE_ADDR + 32'h14;
  assign wr = ce_i & we_i;
  assign rd = ce_i & ~we_i & ~rst;

  // Only the low bits of data_i land in registers
  logic unused_bits;
  assign unused_bits = ^data_i;

  // Input path: sw and btn share one lane vector {btn, sw}
  logic [IN_W-1:0] sync1, sync2, db_q, db_nxt;
  logic [TW-1:0]   tcnt;
  logic            tick;
  assign tick = tcnt == TW'(DB_TICK - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      db_q  <= '0;
      tcnt  <= '0;
    end else begin
      sync1 <= {btn, sw};
      sync2 <= sync1;
      db_q  <= db_nxt;
      tcnt  <= tick ? '0 : tcnt + 1'b1;
    end
  end

  for (genvar i = 0; i < IN_W; i++) begin : g_lane
    risc32_io_db_lane #(.DB_CNT(DB_CNT)) u_lane (
      .clk (clk),
      .rst (rst),
      .tick(tick),
      .din (sync2[i]),
      .dq  (db_q[i]),
      .nxt (db_nxt[i])
    );
  end

  logic [BTN_W-1:0] btn_rise;
  assign btn_rise = db_nxt[IN_W-1:SW_W] & ~db_q[IN_W-1:SW_W];

  // Registers
  logic [SEG_W-1:0] seg_r;
  logic [BTN_W-1:0] evt;
  logic             scan_en, irq_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led     <= '0;
      seg_r   <= '0;
      scan_en <= 1'b1;
      evt     <= '0;
    end else begin
      if (wr && sel_led)  led     <= data_i[LED_W-1:0];
      if (wr && sel_seg)  seg_r   <= data_i[SEG_W-1:0];
      if (wr && sel_ctrl) scan_en <= data_i[0];
      // a new edge on the same cycle as a W1C keeps the flag
      evt <= (evt & ~((wr && sel_evt) ? data_i[BTN_W-1:0] : '0)) | btn_rise;
    end
  end

`ifdef IO_BTN_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en <= 1'b0;
      irq_o  <= 1'b0;
    end else begin
      if (wr && sel_ctrl) irq_en <= data_i[1];
      irq_o <= irq_en & (|evt);
    end
  end
`else
  assign irq_en = 1'b0;
  assign irq_o  = 1'b0;
`endif

  always_comb begin
    data_o = '0;
    if (rd) begin
      if (sel_led)  data_o = 32'(led);
      if (sel_seg)  data_o = 32'(seg_r);
      if (sel_sw)   data_o = 32'(db_q[SW_W-1:0]);
      if (sel_btn)  data_o = 32'(db_q[IN_W-1:SW_W]);
      if (sel_evt)  data_o = 32'(evt);
      if (sel_ctrl) data_o = {30'd0, irq_en, scan_en};
    end
  end

  // Scan: divider and index run regardless of SCAN_EN
  logic [DW-1:0] div;
  logic [IW-1:0] idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div   <= '0;
      idx   <= '0;
      an_o  <= '1;
      seg_o <= 8'hFF;
    end else begin
      an_o  <= scan_en ? ~(DIGITS'(1) << idx) : '1;
      seg_o <= scan_en ? hex7(seg_r[idx*4 +: 4]) : 8'hFF;
      if (div == DW'(SCAN_DIV - 1)) begin
        div <= '0;
        idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        div <= div + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_risc32_io_ctrl.sv
// Randomised bench for risc32_io_ctrl against a cycle-level behavioural model of the register map.
module tb_risc32_io_ctrl;
  localparam logic [31:0] B = 32'h0000_1000;
  localparam int DB_TICK = 4, DB_CNT = 3, SCAN_DIV = 2, DIGITS = 4;

  logic clk = 0, rst = 1, ce = 0, we = 0, irq_o;
  logic [31:0] addr = 0, data_i = 0, data_o;
  logic [15:0] sw = 0, led;
  logic [4:0]  btn = 0;
  logic [3:0]  an_o;
  logic [7:0]  seg_o;

  always #5 clk = ~clk;

  risc32_io_ctrl #(.BASE_ADDR(B), .LED_W(16), .SW_W(16), .BTN_W(5), .DIGITS(DIGITS),
    .SCAN_DIV(SCAN_DIV), .DB_TICK(DB_TICK), .DB_CNT(DB_CNT)) dut (
    .clk(clk), .rst(rst), .ce_i(ce), .we_i(we), .addr_i(addr), .data_i(data_i),
    .data_o(data_o), .sw(sw), .btn(btn), .led(led), .an_o(an_o), .seg_o(seg_o), .irq_o(irq_o));

  int vecs = 0, errs = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model state
  logic [15:0] m_led, m_seg;
  logic        m_en, m_ie, m_irq;
  logic [4:0]  m_evt;
  logic [20:0] m_db, m_h1, m_h2;
  int          m_c[21];
  int          m_n;
  logic [3:0]  m_an;
  logic [7:0]  m_sg;
  logic [15:0] tsw = 0;
  logic [4:0]  tbtn = 0;
  logic [31:0] last_rd;

  function automatic logic [7:0] hex7(input logic [3:0] n);
    logic [7:0] t[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return t[n];
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a == B)         return {16'd0, m_led};
    if (a == B + 'h04)  return {16'd0, m_seg};
    if (a == B + 'h08)  return {16'd0, m_db[15:0]};
    if (a == B + 'h0C)  return {27'd0, m_db[20:16]};
    if (a == B + 'h10)  return {27'd0, m_evt};
    if (a == B + 'h14)  return {30'd0, m_ie, m_en};
    return 0;
  endfunction

  task automatic m_reset();
    m_led = 0; m_seg = 0; m_en = 1; m_ie = 0; m_irq = 0; m_evt = 0;
    m_db = 0; m_h1 = 0; m_h2 = 0; m_n = 0; m_an = 4'hF; m_sg = 8'hFF;
    for (int i = 0; i < 21; i++) m_c[i] = 0;
  endtask

  // One clock edge: outputs from pre-edge state, then state update
  task automatic m_edge();
    int idx;
    logic [20:0] samp;
    logic [4:0] rise, clr;
    idx = (m_n / SCAN_DIV) % DIGITS;
    if (m_en) begin
      m_an = ~(4'b1 << idx);
      m_sg = hex7(4'(m_seg >> (4 * idx)));
    end else begin
      m_an = 4'hF;
      m_sg = 8'hFF;
    end
`ifdef IO_BTN_IRQ_EN
    m_irq = m_ie & (|m_evt);
`endif
    samp = m_h2; m_h2 = m_h1; m_h1 = {btn, sw};
    rise = 0;
    if ((m_n + 1) % DB_TICK == 0)
      for (int i = 0; i < 21; i++) begin
        if (samp[i] != m_db[i]) begin
          m_c[i]++;
          if (m_c[i] == DB_CNT) begin
            m_db[i] = ~m_db[i];
            m_c[i] = 0;
            if (i >= 16 && m_db[i]) rise[i-16] = 1'b1;
          end
        end else m_c[i] = 0;
      end
    clr = 0;
    if (ce && we) begin
      if (addr == B)        m_led = data_i[15:0];
      if (addr == B + 'h04) m_seg = data_i[15:0];
      if (addr == B + 'h10) clr = data_i[4:0];
      if (addr == B + 'h14) begin
        m_en = data_i[0];
`ifdef IO_BTN_IRQ_EN
        m_ie = data_i[1];
`endif
      end
    end
    m_evt = (m_evt & ~clr) | rise;
    m_n++;
  endtask

  task automatic cyc(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    rst = 0; ce = c; we = w; addr = a; data_i = d; sw = tsw; btn = tbtn;
    #1;
    last_rd = data_o;
    chk("rd", data_o, (c && !w) ? m_read(a) : 32'd0);
    m_edge();
    @(posedge clk);
    #1;
    chk("led", {16'd0, led}, {16'd0, m_led});
    chk("an", {28'd0, an_o}, {28'd0, m_an});
    chk("seg", {24'd0, seg_o}, {24'd0, m_sg});
    chk("irq", {31'd0, irq_o}, {31'd0, m_irq});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d); cyc(1, 1, a, d); endtask
  task automatic rd(input logic [31:0] a); cyc(1, 0, a, 0); endtask
  task automatic idle(input int n); for (int i = 0; i < n; i++) cyc(0, 0, 0, 0); endtask

  // Reset stays asserted until the next cyc call releases it
  task automatic do_reset();
    @(negedge clk);
    rst = 1; ce = 1; we = 0; addr = B + 'h10;
    #1;
    chk("rst_led", {16'd0, led}, 0);
    chk("rst_an", {28'd0, an_o}, 32'hF);
    chk("rst_seg", {24'd0, seg_o}, 32'hFF);
    chk("rst_irq", {31'd0, irq_o}, 0);
    chk("rst_rd", data_o, 0);
    m_reset();
  endtask

  initial begin
    m_reset();
    do_reset();
    // LED write/readback and unmapped read
    wr(B, 32'hFFFF_A5A5);
    chk("led_a5", {16'd0, led}, 32'h0000_A5A5);
    rd(B);       chk("rd_led", last_rd, 32'h0000_A5A5);
    rd(B + 'h20); chk("rd_unmap", last_rd, 0);
    // Switch debounce and glitch rejection
    tsw = 16'h00F0; idle(16);
    rd(B + 'h08); chk("sw_f0", last_rd, 32'h0000_00F0);
    tsw = 16'h00F1; idle(3); tsw = 16'h00F0; idle(20);
    rd(B + 'h08); chk("sw_glitch", last_rd, 32'h0000_00F0);
    // Button events and W1C
    tbtn = 5'h04; idle(20);
    rd(B + 'h10); chk("evt_4", last_rd, 32'h4);
    wr(B + 'h10, 0); rd(B + 'h10); chk("evt_w0", last_rd, 32'h4);
    wr(B + 'h10, 4); rd(B + 'h10); chk("evt_w1c", last_rd, 0);
    tbtn = 0; idle(20);
    tbtn = 5'h02;
    for (int i = 0; i < 40 && !m_evt[1]; i++) wr(B + 'h10, 2);
    rd(B + 'h10); chk("evt_setwins", last_rd, 32'h2);
    wr(B + 'h10, 32'h1F);
    // Scan
    wr(B + 'h04, 32'h1234); wr(B + 'h14, 1); idle(16);
    wr(B + 'h14, 0); idle(1);
    chk("scan_off_an", {28'd0, an_o}, 32'hF);
    chk("scan_off_seg", {24'd0, seg_o}, 32'hFF);
    // Interrupt
    wr(B + 'h14, 3); tbtn = 5'h01; idle(20);
    rd(B + 'h14);
`ifdef IO_BTN_IRQ_EN
    chk("irq_on", {31'd0, irq_o}, 1);
    chk("ctrl_3", last_rd, 3);
`else
    chk("irq_off", {31'd0, irq_o}, 0);
    chk("ctrl_1", last_rd, 1);
`endif
    wr(B + 'h10, 1); idle(1);
    chk("irq_clr", {31'd0, irq_o}, 0);
    // Reset mid-scan
    wr(B + 'h14, 1); wr(B, 32'hFFFF); tbtn = 0; idle(20); tbtn = 5'h05; idle(20);
    rd(B + 'h10); chk("evt_5", last_rd, 32'h5);
    idle(3);
    do_reset();
    idle(1);
    chk("scan_restart_an", {28'd0, an_o}, 32'hE);
    chk("scan_restart_seg", {24'd0, seg_o}, 32'hC0);
    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] a;
      a = B + 4 * $urandom_range(0, 7);
      if ($urandom_range(0, 15) == 0) a = $urandom;
      if ($urandom_range(0, 11) == 0) tsw = tsw ^ 16'($urandom);
      if ($urandom_range(0, 11) == 0) tbtn = tbtn ^ 5'($urandom);
      if ($urandom_range(0, 799) == 0) do_reset();
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, a, $urandom);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
